lsu: RTL and testbench

Load/store unit between the core's execute stage and the data-memory port (`daddr`/`din`/`dout`/`wen`/`rd`). It accepts one RV32I load or store per handshake, performs byte-lane alignment, issues the memory access, waits a fixed memory latency, and returns sign/zero-extended load data or a store completion. It also rejects misaligned and illegal-size requests without touching memory.

---
 rtl/lsu.sv | 209 ++++++++++++++++++++
 tb/tb_lsu.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// RV32I load/store unit: byte-lane alignment, memory access, load extension, error rejection.
// Latency: store 2 cycles, load MEM_LATENCY+2 cycles, error 1 cycle (accept edge to resp_valid).
// Backpressure: req_ready is high only in IDLE (one transaction in flight); responses cannot be stalled.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake; req_we, req_funct3, req_addr, req_wdata describe the access
//   resp_valid           : one-cycle completion pulse carrying resp_rdata (extended load data) and resp_err
//   daddr, dout, wen, rd : data-memory port outputs (word address, replicated store data, byte enables, read strobe)
//   din                  : data-memory read data, valid MEM_LATENCY cycles after the rd cycle
module lsu #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dout,
  output logic [3:0]  wen,
  output logic        rd,
  input  logic [31:0] din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // WAIT counts down from MEM_LATENCY-1 to 0, so it lasts MEM_LATENCY cycles (1..4 fits in 2 bits).
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        rd_q;
  logic [3:0]  wen_q;
  logic [31:0] daddr_q;
  logic [31:0] dout_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  // Request decode, evaluated on the incoming request while in IDLE.
  logic        req_legal;
  logic        req_misal;
  logic        req_err;
  logic [3:0]  st_wen;
  logic [31:0] st_dout;

  always_comb begin
    req_legal = 1'b0;
    req_misal = 1'b0;
    st_wen    = 4'b0000;
    st_dout   = 32'h0;

    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end

    req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    case (req_funct3[1:0])
      2'b00: begin
        st_wen  = 4'b0001 << req_addr[1:0];
        st_dout = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_wen  = 4'b0011 << req_addr[1:0];
        st_dout = {2{req_wdata[15:0]}};
      end
      default: begin
        st_wen  = 4'b1111;
        st_dout = req_wdata;
      end
    endcase
  end

  assign req_err = !req_legal || req_misal;

  // Load extraction from the captured word, using the latched offset and funct3.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = 8'h0;
    ld_data = din;
    case (off_q)
      2'd0:    ld_byte = din[7:0];
      2'd1:    ld_byte = din[15:8];
      2'd2:    ld_byte = din[23:16];
      default: ld_byte = din[31:24];
    endcase
    ld_half = off_q[1] ? din[31:16] : din[15:0];

    case (funct3_q[1:0])
      2'b00:   ld_data = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = din;
    endcase
  end

  // Single FSM process; every output is registered and defaults to zero each cycle,
  // so bus strobes and response fields are only non-zero in their owning state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'd0;
      rd_q         <= 1'b0;
      wen_q        <= 4'b0000;
      daddr_q      <= 32'h0;
      dout_q       <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      rd_q         <= 1'b0;
      wen_q        <= 4'b0000;
      daddr_q      <= 32'h0;
      dout_q       <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            if (req_err) begin
              // Rejected without any bus activity.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
              daddr_q <= {req_addr[31:2], 2'b00};
              if (req_we) begin
                wen_q  <= st_wen;
                dout_q <= st_dout;
              end else begin
                rd_q <= 1'b1;
              end
            end
          end
        end

        ACCESS: begin
          if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
          end
        end

        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_data;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rd         = rd_q;
  assign wen        = wen_q;
  assign daddr      = daddr_q;
  assign dout       = dout_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a driver issues requests and queues expected bus/response events,
// a negedge monitor pops and compares them, and a memory responder drives din with the right
// word only in the cycle MEM_LATENCY after rd (random data otherwise).
module tb_lsu;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] daddr;
  logic [31:0] dout;
  logic [3:0]  wen;
  logic        rd;
  logic [31:0] din = 32'h0;

  lsu #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .daddr      (daddr),
    .dout       (dout),
    .wen        (wen),
    .rd         (rd),
    .din        (din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [3:0]  wen;
    logic [31:0] daddr;
    logic [31:0] dout;
  } bus_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } rdsched_t;

  resp_t    resp_q[$];
  bus_t     bus_q[$];
  rdsched_t din_q[$];

  logic [31:0] mem [logic [29:0]];

  int checks = 0;
  int failures = 0;
  bit started = 0;
  int last_a = 0;
  int last_resp = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rdword(input logic [31:0] a);
    logic [29:0] k;
    k = a[31:2];
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  // Reference behaviour from the RV32I access rules: size in bytes, alignment by modulo,
  // store data replication by multiplication, load extraction by shift and mask.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err,
                                output logic [3:0] wen_e, output logic [31:0] dout_e,
                                output logic [31:0] rdata_e);
    int size;
    int o;
    int m;
    logic legal;
    logic [31:0] w;
    logic [31:0] mask;
    logic [31:0] v;
    size = 1 << f3[1:0];
    o = int'(addr[1:0]);
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    err = !legal || ((o % size) != 0);
    wen_e = 4'h0;
    dout_e = 32'h0;
    rdata_e = 32'h0;
    if (err) return;
    if (we) begin
      m = ((1 << size) - 1) << o;
      wen_e = m[3:0];
      if (size == 1)      dout_e = (wdata & 32'hFF) * 32'h01010101;
      else if (size == 2) dout_e = (wdata & 32'hFFFF) * 32'h00010001;
      else                dout_e = wdata;
    end else begin
      w = rdword(addr);
      if (size == 1)      mask = 32'hFF;
      else if (size == 2) mask = 32'hFFFF;
      else                mask = 32'hFFFF_FFFF;
      v = (w >> (8 * o)) & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      rdata_e = v;
    end
  endfunction

  // Drive one request; returns at posedge+1 of the ACCESS (or error-RESP) cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic err;
    logic [3:0] wen_e;
    logic [31:0] dout_e;
    logic [31:0] rdata_e;
    int n;
    int a;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    model(we, f3, addr, wdata, err, wen_e, dout_e, rdata_e);
    a = cyc + 1;
    if (!err) bus_q.push_back('{a, !we, wen_e, {addr[31:2], 2'b00}, dout_e});
    resp_q.push_back('{a + (err ? 0 : (we ? 1 : LAT + 1)), rdata_e, err});
    last_a = a;
    last_resp = a + (err ? 0 : (we ? 1 : LAT + 1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  // Memory responder: correct word only in cycle rd+LAT.
  always @(negedge clk) begin
    if (reset) begin
      din_q.delete();
      din = $urandom;
    end else begin
      if (rd) din_q.push_back('{cyc + LAT, daddr});
      if (din_q.size() > 0 && din_q[0].cyc == cyc) begin
        din = rdword(din_q[0].addr);
        void'(din_q.pop_front());
      end else begin
        din = $urandom;
      end
    end
  end

  // Monitor: compares every response and every bus cycle against the queued expectations.
  resp_t r;
  bus_t  b;
  always @(negedge clk) begin
    if (reset) begin
      resp_q.delete();
      bus_q.delete();
    end else if (started) begin
      chk("req_ready", {31'h0, req_ready},
          {31'h0, !(cyc >= last_a && cyc <= last_resp)});
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp @cyc %0d: got resp_valid=1 expected none", cyc);
        end else begin
          r = resp_q.pop_front();
          chk("resp_cycle", cyc, r.cyc);
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
        end
      end else begin
        chk("resp_idle", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'h0);
      end
      if (rd || wen != 4'h0) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bus @cyc %0d: got rd=%b wen=%b expected idle bus", cyc, rd, wen);
        end else begin
          b = bus_q.pop_front();
          chk("bus_cycle", cyc, b.cyc);
          chk("bus_rd", {31'h0, rd}, {31'h0, b.rd});
          chk("bus_wen", {28'h0, wen}, {28'h0, b.wen});
          chk("bus_daddr", daddr, b.daddr);
          chk("bus_dout", dout, b.dout);
        end
      end else begin
        chk("bus_idle", daddr | dout, 32'h0);
      end
    end
  end

  logic [2:0] legal_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};

  initial begin
    logic       we;
    logic [2:0] f3;
    logic [31:0] addr;

    mem[30'h010] = 32'hCAFEF00D;   // 0x40
    mem[30'h080] = 32'h12F45678;   // 0x200

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    started = 1;
    @(negedge clk);
    chk("reset_outputs", {resp_rdata[31:1], resp_rdata[0] | resp_valid | resp_err | rd} | daddr | dout | {28'h0, wen}, 32'h0);
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Directed cases.
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);   // SW
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);   // SB top byte
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF);   // SH upper half
    issue(1'b0, 3'b000, 32'h0000_0202, 32'h0);           // LB  -> FFFFFFF4
    issue(1'b0, 3'b100, 32'h0000_0202, 32'h0);           // LBU -> 000000F4
    issue(1'b0, 3'b101, 32'h0000_0202, 32'h0);           // LHU -> 000012F4
    issue(1'b0, 3'b000, 32'h0000_0200, 32'h0);           // LH? no: LB @0x200 -> 00000078
    issue(1'b0, 3'b001, 32'h0000_0200, 32'h0);           // LH  -> 00005678
    issue(1'b0, 3'b001, 32'h0000_0201, 32'h0);           // LH misaligned
    issue(1'b0, 3'b011, 32'h0000_0200, 32'h0);           // illegal load funct3
    issue(1'b1, 3'b100, 32'h0000_0200, 32'h0);           // illegal store funct3
    issue(1'b1, 3'b010, 32'h0000_0202, 32'h0);           // SW misaligned
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);           // LW long latency

    // Reset during WAIT of a load: nothing may complete afterwards.
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    last_a = 0;
    last_resp = -1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {30'h0, resp_valid, rd}, 32'h0);
    end
    @(posedge clk);
    #1;
    issue(1'b1, 3'b010, 32'h0000_0100, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 7)];
      else                          f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) addr = $urandom;
      else                           addr = 32'h0000_1000 + 32'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(we, f3, addr, $urandom);
    end

    // Drain.
    for (int i = 0; i < 20 && resp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within 50000 cycles");
    $fatal(1, "timeout");
  end

endmodule
